// File: rtl/countdown_pkg.sv
// Purpose: shared definitions for the countdown timer. This package holds the
//          FSM state encoding and the default count width.
// Ports:   none (package)
package countdown_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : countdown_pkg

// File: rtl/countdown_timer_if.sv
// Purpose: control and status bundle for countdown_timer.
// Ports (signals):
//   enable      - count-down qualifier
//   load        - parallel load strobe
//   parallel_in - load / reload value (WIDTH bits)
//   auto_reload - 1 = periodic mode, 0 = one-shot mode
//   cout        - current count (registered)
//   tc          - terminal-count pulse (registered, one cycle)
//   busy        - state is RUN
//   done        - state is DONE
// Modports: master drives the controls, slave is the timer.
interface countdown_timer_if #(
  parameter int WIDTH = countdown_pkg::DEFAULT_WIDTH
);

  logic             enable;
  logic             load;
  logic [WIDTH-1:0] parallel_in;
  logic             auto_reload;
  logic [WIDTH-1:0] cout;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output enable, load, parallel_in, auto_reload,
    input  cout, tc, busy, done
  );

  modport slave (
    input  enable, load, parallel_in, auto_reload,
    output cout, tc, busy, done
  );

endinterface : countdown_timer_if

// File: rtl/countdown_timer.sv
// Purpose: loadable down-counter with one-shot and periodic modes. It emits
//          a registered terminal-count pulse each time the count expires.
// Ports:
//   clk   - single clock, rising edge
//   reset - asynchronous, active-high reset
//   bus   - countdown_timer_if.slave (controls in, cout/tc/busy/done out)
//
// state | meaning
// IDLE  | no count in progress (after reset or a load of 0)
// RUN   | counting down on enabled cycles
// DONE  | one-shot count expired; cout holds 0 until the next load
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  countdown_timer_if.slave    bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_cout;
  logic [WIDTH-1:0] w_cout_nxt;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             r_tc;
  logic             w_tc_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cout   <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cout   <= w_cout_nxt;
      r_reload <= w_reload_nxt;
      r_tc     <= w_tc_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cout_nxt   = r_cout;
    w_reload_nxt = r_reload;
    w_tc_nxt     = 1'b0;

    if (bus.load) begin
      // A load overrides everything, including a coincident terminal count.
      w_cout_nxt   = bus.parallel_in;
      w_reload_nxt = bus.parallel_in;
      w_state_nxt  = (bus.parallel_in != '0) ? RUN : IDLE;
    end else begin
      unique case (r_state)
        RUN: begin
          if (bus.enable) begin
            if (r_cout > ONE) begin
              w_cout_nxt = r_cout - ONE;
            end else begin
              // RUN is only reached with a non-zero count, so this branch is
              // the expiry step (cout == 1).
              w_tc_nxt = 1'b1;
              if (bus.auto_reload) begin
                w_cout_nxt = r_reload;
              end else begin
                w_cout_nxt  = '0;
                w_state_nxt = DONE;
              end
            end
          end
        end
        IDLE, DONE: begin
          w_state_nxt = r_state;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign bus.cout = r_cout;
  assign bus.tc   = r_tc;
  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  localparam int WIDTH = 4;

  logic clk;
  logic reset;

  countdown_timer_if #(.WIDTH(WIDTH)) u_if ();

  countdown_timer #(.WIDTH(WIDTH)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the count remaining and the running/expired flags.
  int m_count;
  int m_period;
  bit m_running;
  bit m_expired;
  bit m_pulse;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_period = 0; m_running = 0; m_expired = 0; m_pulse = 0;
  endtask

  task automatic model_edge(input bit en, input bit ld, input int pin, input bit ar);
    m_pulse = 0;
    if (ld) begin
      m_count   = pin;
      m_period  = pin;
      m_running = (pin != 0);
      m_expired = 0;
    end else if (m_running && en) begin
      if (m_count - 1 == 0) begin
        m_pulse = 1;
        if (ar) m_count = m_period;
        else begin
          m_count = 0; m_running = 0; m_expired = 1;
        end
      end else begin
        m_count = m_count - 1;
      end
    end
  endtask

  task automatic cmp_model(input string where);
    chk({where, ".cout"}, int'(u_if.cout), m_count);
    chk({where, ".tc"},   int'(u_if.tc),   int'(m_pulse));
    chk({where, ".busy"}, int'(u_if.busy), int'(m_running));
    chk({where, ".done"}, int'(u_if.done), int'(m_expired));
  endtask

  // One clock: drive on the falling edge, update the model at the rising
  // edge, compare 1 ns later.
  task automatic step(input bit rs, input bit en, input bit ld, input int pin, input bit ar);
    @(negedge clk);
    reset              = rs;
    u_if.enable        = en;
    u_if.load          = ld;
    u_if.parallel_in   = WIDTH'(pin);
    u_if.auto_reload   = ar;
    if (rs) begin
      #1;
      model_reset();
      cmp_model("async_rst");
    end
    @(posedge clk);
    if (!rs) model_edge(en, ld, pin, ar);
    #1;
    cmp_model("step");
  endtask

  int tc_cnt;
  int cyc;
  bit seen;
  bit ar_r;

  initial begin
    reset = 1'b1;
    u_if.enable = 0; u_if.load = 0; u_if.parallel_in = '0; u_if.auto_reload = 0;
    model_reset();
    #2;
    chk("rst.cout", int'(u_if.cout), 0);
    chk("rst.tc",   int'(u_if.tc),   0);
    chk("rst.busy", int'(u_if.busy), 0);
    chk("rst.done", int'(u_if.done), 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // One-shot: load 3 -> 3,2,1,0 with tc alongside 0, then DONE holding 0.
    step(0, 1, 1, 3, 0);
    chk("os.load", int'(u_if.cout), 3);
    step(0, 1, 0, 0, 0); chk("os.c2", int'(u_if.cout), 2);
    step(0, 1, 0, 0, 0); chk("os.c1", int'(u_if.cout), 1);
    step(0, 1, 0, 0, 0);
    chk("os.c0", int'(u_if.cout), 0);
    chk("os.tc", int'(u_if.tc), 1);
    chk("os.done", int'(u_if.done), 1);
    chk("os.busy", int'(u_if.busy), 0);
    step(0, 1, 0, 0, 0);
    chk("os.hold", int'(u_if.cout), 0);
    chk("os.tc_once", int'(u_if.tc), 0);

    // Periodic: load 4, 12 enabled cycles -> 3 pulses, cout never 0.
    step(0, 1, 1, 4, 1);
    tc_cnt = 0; seen = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0, 0, 1);
      if (u_if.tc) tc_cnt++;
      if (u_if.cout == '0) seen = 1;
    end
    chk("per.pulses", tc_cnt, 3);
    chk("per.zero_seen", int'(seen), 0);
    chk("per.cout", int'(u_if.cout), 4);

    // Enable gating: load 5, enable 1,0,0,1 -> 4,4,4,3.
    step(0, 1, 1, 5, 0);
    step(0, 1, 0, 0, 0); chk("en.a", int'(u_if.cout), 4);
    step(0, 0, 0, 0, 0); chk("en.b", int'(u_if.cout), 4);
    step(0, 0, 0, 0, 0); chk("en.c", int'(u_if.cout), 4);
    step(0, 1, 0, 0, 0); chk("en.d", int'(u_if.cout), 3);
    chk("en.tc", int'(u_if.tc), 0);

    // Load conflicts.
    step(0, 1, 1, 0, 0);
    chk("ld0.busy", int'(u_if.busy), 0);
    chk("ld0.tc", int'(u_if.tc), 0);
    step(0, 1, 1, 2, 0);
    step(0, 1, 0, 0, 0); chk("ldc.pre", int'(u_if.cout), 1);
    step(0, 1, 1, 7, 0);
    chk("ldc.cout", int'(u_if.cout), 7);
    chk("ldc.tc", int'(u_if.tc), 0);
    chk("ldc.busy", int'(u_if.busy), 1);

    // Reset mid-count at cout=5.
    step(0, 1, 1, 8, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    chk("rmc.pre", int'(u_if.cout), 5);
    step(1, 1, 0, 0, 0);
    chk("rmc.cout", int'(u_if.cout), 0);
    chk("rmc.busy", int'(u_if.busy), 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 0, 0);
      if (u_if.tc || u_if.busy) seen = 1;
    end
    chk("rmc.quiet", int'(seen), 0);

    // Full-scale one-shot: 15 enabled cycles to tc, no wrap afterwards.
    step(0, 1, 1, 15, 0);
    cyc = 0;
    while (!u_if.tc && cyc < 40) begin
      step(0, 1, 0, 0, 0);
      cyc++;
    end
    chk("fs.cycles", cyc, 15);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
    chk("fs.nowrap", int'(u_if.cout), 0);

    // Periodic with reload 1: tc every cycle.
    step(0, 1, 1, 1, 1);
    tc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 1);
      if (u_if.tc) tc_cnt++;
    end
    chk("r1.pulses", tc_cnt, 5);

    // Random traffic against the model.
    ar_r = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) ar_r = ~ar_r;
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 11) == 0),
           (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 15))),
           ar_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_countdown_timer
